// File: rtl/rx78_busctl.sv
// RX-78 bus controller: memory decode, VRAM plane enables, I/O registers,
// vblank interrupt and VRAM wait states. Optional readback: RX78_BUSCTL_RDBACK_EN.
module rx78_busctl #(
    parameter int NPLANES = 6,
    parameter int NPAL    = 6,
    parameter int VWAIT   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         zaddr,
    input  logic [7:0]          zdo,
    input  logic                mreq_n,
    input  logic                iorq_n,
    input  logic                wr_n,
    input  logic                m1_n,
    input  logic                vb,
    output logic [3:0]          mem_sel,
    output logic [NPLANES-1:0]  plane_ce_n,
    output logic [NPAL*8-1:0]   pal,
    output logic [7:0]          mask,
    output logic [7:0]          io_q,
    output logic                io_oe,
    output logic                int_n,
    output logic                wait_n
);

    logic [7:0] rd_bank;
    logic [7:0] wr_bank;
    logic [7:0] bank;
    logic [7:0] ce_all;
    logic [7:0] port;
    logic       io_wr;
    logic       io_wr_q;
    logic       io_commit;
    logic       ack;
    logic       vb_q;
    logic       pending;
    logic       mreq_q;
    logic       vstart;
    logic [3:0] wcnt;

    assign port      = zaddr[7:0];
    assign io_wr     = !iorq_n && !wr_n && m1_n;
    assign io_commit = io_wr && !io_wr_q;
    assign ack       = !iorq_n && !m1_n;

    // Address decode into one-hot region selects; all zero selects ROM
    always_comb begin
        mem_sel = 4'b0000;
        if (!mreq_n) begin
            if (zaddr >= 16'hEC00)      mem_sel = 4'b1000;
            else if (zaddr >= 16'hB000) mem_sel = 4'b0100;
            else if (zaddr >= 16'h6000) mem_sel = 4'b0010;
            else if (zaddr >= 16'h2000) mem_sel = 4'b0001;
        end
    end

    assign bank       = wr_n ? rd_bank : wr_bank;
    assign ce_all     = ~({8{mem_sel[3]}} & bank);
    assign plane_ce_n = ce_all[NPLANES-1:0];

    // I/O register writes, committed once on the leading cycle of a write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_wr_q <= 1'b0;
            rd_bank <= 8'h00;
            wr_bank <= 8'h00;
            pal     <= '0;
            mask    <= 8'h00;
        end else begin
            io_wr_q <= io_wr;
            if (io_commit) begin
                if (port == 8'hF1) rd_bank <= zdo;
                if (port == 8'hF2) wr_bank <= zdo;
                if (port == 8'hFE) mask    <= zdo;
                for (int i = 0; i < NPAL; i++) begin
                    if (port == 8'(245 + i)) pal[8*i +: 8] <= zdo;
                end
            end
        end
    end

    // Vblank edge sets the pending interrupt; acknowledge clears, set wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vb_q    <= 1'b0;
            pending <= 1'b0;
        end else begin
            vb_q <= vb;
            if (vb && !vb_q)  pending <= 1'b1;
            else if (ack)     pending <= 1'b0;
        end
    end

    assign int_n = ~pending;

    assign vstart = mreq_q && !mreq_n && mem_sel[3];

    // Wait-state counter loaded on each new VRAM access start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mreq_q <= 1'b1;
            wcnt   <= 4'd0;
        end else begin
            mreq_q <= mreq_n;
            if (vstart)           wcnt <= 4'(VWAIT);
            else if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
        end
    end

    assign wait_n = (wcnt == 4'd0);

`ifdef RX78_BUSCTL_RDBACK_EN
    logic       io_rd;
    logic       rd_hit;
    logic [7:0] rd_val;

    assign io_rd = !iorq_n && wr_n && m1_n;

    // Select the register addressed by an I/O read
    always_comb begin
        rd_hit = 1'b0;
        rd_val = 8'h00;
        if (port == 8'hF1) begin rd_hit = 1'b1; rd_val = rd_bank; end
        if (port == 8'hF2) begin rd_hit = 1'b1; rd_val = wr_bank; end
        if (port == 8'hFE) begin rd_hit = 1'b1; rd_val = mask;    end
        for (int i = 0; i < NPAL; i++) begin
            if (port == 8'(245 + i)) begin
                rd_hit = 1'b1;
                rd_val = pal[8*i +: 8];
            end
        end
    end

    // Registered readback data, one clock after the read cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_q  <= 8'h00;
            io_oe <= 1'b0;
        end else begin
            io_oe <= io_rd && rd_hit;
            io_q  <= (io_rd && rd_hit) ? rd_val : 8'h00;
        end
    end
`else
    assign io_q  = 8'h00;
    assign io_oe = 1'b0;
`endif

endmodule
